// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit controller: default bus
// addresses, status word bit positions and the transmit FSM encoding.
package uart_tx_ctrl_pkg;

  // Default dpram status word address and CPU transmit data address
  localparam logic [11:0] STATUS_ADDR_DEF = 12'h800;
  localparam logic [11:0] DATA_ADDR_DEF   = 12'h801;

  // Status word bit positions
  localparam int ST_NOTFULL = 0;
  localparam int ST_IDLE    = 1;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_OVF     = 15;

  // Transmit sequencer states
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_LOAD  = 2'd1,
    TX_START = 2'd2,
    TX_WAIT  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO, depth 2**FIFO_AW. A push while full is ignored
// even if a pop happens in the same cycle; count saturates at the depth.
import uart_tx_ctrl_pkg::*;

module uart_tx_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic             clock,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] count
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Count reaches exactly DEPTH when full, which is its MSB alone
  assign full    = count[FIFO_AW];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array, written on an accepted push
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap modulo depth; count tracks occupancy
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmit controller. Snoops CPU writes to DATA_ADDR,
// queues the low byte, drives uart_tx through its start/ready handshake
// and mirrors a status word into dpram port 2 whenever it changes.
// Optional sticky overflow flag (status bit15) built with UART_TX_OVF_EN.
import uart_tx_ctrl_pkg::*;

module uart_tx_ctrl #(
  parameter logic [11:0] STATUS_ADDR = STATUS_ADDR_DEF,
  parameter logic [11:0] DATA_ADDR   = DATA_ADDR_DEF,
  parameter int          FIFO_AW     = 4
) (
  input  logic        clock,
  input  logic        n_rst,
  input  logic [11:0] bus_addr,
  input  logic [15:0] bus_wdata,
  input  logic        bus_we,
  output logic [11:0] dp_addr,
  output logic [15:0] dp_din,
  output logic        dp_we,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready
);

  // Handshake with uart_tx: tx_start is raised in START and held until
  // tx_ready is sampled low (uart_tx has taken the byte); the controller
  // then waits for tx_ready to return high before offering another byte.
  // Holding start this way tolerates uart_tx running on a slower clock.

  tx_state_e          state;
  tx_state_e          state_nxt;
  logic               push_req;
  logic               fifo_pop;
  logic [7:0]         fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_AW:0]   fifo_count;
  logic [15:0]        status;
  logic [15:0]        shadow;
  logic               ovf_flag;
  logic               unused_bits;

  assign push_req = bus_we && (bus_addr == DATA_ADDR);

  uart_tx_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clock (clock),
    .n_rst (n_rst),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (bus_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sequencer state register
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) state <= TX_IDLE;
    else        state <= state_nxt;
  end

  // Sequencer next state, FIFO pop and start request
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    tx_start  = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) state_nxt = TX_LOAD;
      end
      TX_LOAD: begin
        fifo_pop  = 1'b1;
        state_nxt = TX_START;
      end
      TX_START: begin
        tx_start = 1'b1;
        if (!tx_ready) state_nxt = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_ready) state_nxt = TX_IDLE;
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  // Byte presented to uart_tx; captured at LOAD and held until the next LOAD
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst)                tx_data <= 8'h00;
    else if (state == TX_LOAD) tx_data <= fifo_dout;
  end

`ifdef UART_TX_OVF_EN
  logic clr_req;
  assign clr_req     = bus_we && (bus_addr == STATUS_ADDR) && bus_wdata[ST_OVF];
  assign unused_bits = ^bus_wdata[14:8];

  // Sticky overflow flag; a new overflow wins over a software clear
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst)                     ovf_flag <= 1'b0;
    else if (push_req && fifo_full) ovf_flag <= 1'b1;
    else if (clr_req)               ovf_flag <= 1'b0;
  end
`else
  assign ovf_flag    = 1'b0;
  assign unused_bits = ^bus_wdata[15:8];
`endif

  // Live status word assembled from FIFO and sequencer state
  always_comb begin
    status                             = '0;
    status[ST_NOTFULL]                 = !fifo_full;
    status[ST_IDLE]                    = fifo_empty && (state == TX_IDLE);
    status[ST_CNT_LSB +: FIFO_AW+1]    = fifo_count;
    status[ST_OVF]                     = ovf_flag;
  end

  // Write the status to dpram one cycle after it differs from the last
  // value written; the shadow doubles as the port-2 write data
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      shadow <= 16'h0000;
      dp_we  <= 1'b0;
    end else if (status != shadow) begin
      shadow <= status;
      dp_we  <= 1'b1;
    end else begin
      dp_we  <= 1'b0;
    end
  end

  assign dp_din  = shadow;
  assign dp_addr = STATUS_ADDR;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: reset status write, single byte with a
// slow uart model, burst, overflow, push during LOAD pop, reset mid-START.
module tb_uart_tx_ctrl;

  localparam logic [11:0] STATUS_ADDR = 12'h800;
  localparam logic [11:0] DATA_ADDR   = 12'h801;

  logic        clock = 1'b0;
  logic        n_rst;
  logic [11:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we;
  logic [11:0] dp_addr;
  logic [15:0] dp_din;
  logic        dp_we;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;

  logic        tb_ready;
  logic        model_ready;
  bit          model_en;
  int          hold_err;

  int checks   = 0;
  int failures = 0;

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  byte_q[$];
  logic [7:0]  exp_b_q[$];

  assign tx_ready = model_en ? model_ready : tb_ready;

  // clock / reset
  always #5 clock = ~clock;

  uart_tx_ctrl dut (
    .clock     (clock),
    .n_rst     (n_rst),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .dp_addr   (dp_addr),
    .dp_din    (dp_din),
    .dp_we     (dp_we),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_ready  (tx_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // record every dpram status write
  always @(negedge clock) begin
    if (n_rst && dp_we) got_q.push_back(dp_din);
  end

  // uart model: drop ready 3 cycles into start, raise it 20 cycles later
  initial begin : uart_model
    int  cnt;
    bit  busy;
    cnt = 0;
    busy = 0;
    model_ready = 1'b1;
    hold_err = 0;
    forever begin
      @(negedge clock);
      if (!model_en) begin
        cnt = 0;
        busy = 0;
        model_ready = 1'b1;
      end else if (!busy) begin
        if (tx_start) begin
          cnt++;
          if (cnt == 3) begin
            byte_q.push_back(tx_data);
            model_ready = 1'b0;
            busy = 1;
            cnt = 0;
          end
        end else if (cnt > 0) begin
          hold_err++;
          cnt = 0;
        end
      end else begin
        if (cnt == 0 && tx_start) hold_err++;
        cnt++;
        if (cnt == 20) begin
          model_ready = 1'b1;
          busy = 0;
          cnt = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [15:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    @(negedge clock);
    bus_we    = 1'b0;
    bus_addr  = 12'h000;
    bus_wdata = 16'h0000;
  endtask

  // scoreboard: status writes
  task automatic check_status_log(input string tag);
    check($sformatf("%s_nwr", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // scoreboard: transmitted bytes
  task automatic check_bytes(input string tag);
    check($sformatf("%s_nbytes", tag), byte_q.size(), exp_b_q.size());
    for (int i = 0; i < exp_b_q.size() && i < byte_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), byte_q[i], exp_b_q[i]);
    byte_q.delete();
    exp_b_q.delete();
  endtask

  initial begin : main
    int peak;
    n_rst     = 1'b0;
    bus_addr  = 12'h000;
    bus_wdata = 16'h0000;
    bus_we    = 1'b0;
    tb_ready  = 1'b1;
    model_en  = 0;
    cycles(2);

    // reset values
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_dp_we", dp_we, 1'b0);
    check("rst_dp_din", dp_din, 16'h0000);
    check("rst_dp_addr", dp_addr, STATUS_ADDR);

    // 1: release reset, single status write of 0x0003
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("t1_tx_start", tx_start, 1'b0);
    end
    check("t1_dp_addr", dp_addr, STATUS_ADDR);
    exp_q.push_back(16'h0003);
    check_status_log("t1");

    // 2: one byte through the slow uart model
    model_en = 1;
    bus_write(DATA_ADDR, 16'h0141);
    cycles(40);
    check("t2_tx_data", tx_data, 8'h41);
    check("t2_hold", hold_err, 0);
    exp_q.push_back(16'h0101);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0003);
    check_status_log("t2");
    exp_b_q.push_back(8'h41);
    check_bytes("t2");

    // 3: burst of five bytes on consecutive cycles
    for (int i = 0; i < 5; i++) begin
      bus_addr  = DATA_ADDR;
      bus_wdata = 16'h0010 + 16'(i);
      bus_we    = 1'b1;
      @(negedge clock);
    end
    bus_we = 1'b0;
    cycles(200);
    peak = 0;
    foreach (got_q[i]) if (int'(got_q[i][12:8]) > peak) peak = int'(got_q[i][12:8]);
    check("t3_peak", peak, 4);
    check("t3_final", dp_din, 16'h0003);
    got_q.delete();
    for (int i = 0; i < 5; i++) exp_b_q.push_back(8'h10 + 8'(i));
    check_bytes("t3");

    // 4: uart stalled, 17 writes overflow a 16-deep FIFO
    model_en = 0;
    tb_ready = 1'b0;
    bus_write(DATA_ADDR, 16'h00aa);
    cycles(5);
    for (int i = 0; i < 17; i++) bus_write(DATA_ADDR, 16'h0020 + 16'(i));
    cycles(3);
`ifdef UART_TX_OVF_EN
    check("t4_full_status", dp_din, 16'h9000);
`else
    check("t4_full_status", dp_din, 16'h1000);
`endif
    bus_write(STATUS_ADDR, 16'h8000);
    cycles(3);
    check("t4_after_clear", dp_din, 16'h1000);
    got_q.delete();
    model_en = 1;
    cycles(520);
    check("t4_drained", dp_din, 16'h0003);
    check("t4_hold", hold_err, 0);
    got_q.delete();
    for (int i = 0; i < 16; i++) exp_b_q.push_back(8'h20 + 8'(i));
    check_bytes("t4");

    // 5: push in the same cycle as the LOAD pop with three queued
    tb_ready = 1'b1;
    model_en = 0;
    bus_write(DATA_ADDR, 16'h0055);
    cycles(4);
    tb_ready = 1'b0;
    cycles(2);
    bus_write(DATA_ADDR, 16'h0061);
    bus_write(DATA_ADDR, 16'h0062);
    bus_write(DATA_ADDR, 16'h0063);
    cycles(3);
    check("t5_pre", dp_din, 16'h0301);
    got_q.delete();
    tb_ready = 1'b1;
    cycles(2);
    bus_write(DATA_ADDR, 16'h0064);
    cycles(4);
    check("t5_nwr", got_q.size(), 0);
    check("t5_status", dp_din, 16'h0301);
    check("t5_tx_start", tx_start, 1'b1);
    check("t5_tx_data", tx_data, 8'h61);
    model_en = 1;
    cycles(160);
    check("t5_drained", dp_din, 16'h0003);
    got_q.delete();
    for (int i = 0; i < 4; i++) exp_b_q.push_back(8'h61 + 8'(i));
    check_bytes("t5");

    // 6: reset asserted while START is driving tx_start
    model_en = 0;
    tb_ready = 1'b1;
    bus_write(DATA_ADDR, 16'h0077);
    bus_write(DATA_ADDR, 16'h0078);
    cycles(1);
    check("t6_pre_start", tx_start, 1'b1);
    n_rst = 1'b0;
    #1;
    check("t6_start_drop", tx_start, 1'b0);
    check("t6_tx_data", tx_data, 8'h00);
    check("t6_dp_we", dp_we, 1'b0);
    got_q.delete();
    cycles(2);
    n_rst = 1'b1;
    cycles(5);
    check("t6_tx_start", tx_start, 1'b0);
    check("t6_status", dp_din, 16'h0003);
    exp_q.push_back(16'h0003);
    check_status_log("t6");
    check("end_hold", hold_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
